seg7_capture: RTL
=================

SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 The block SHALL have parameter STABLE_CYC, default 4, giving the consecutive equal samples required before capture (legal range 1..255).
REQ-002 The block SHALL have port CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 The block SHALL have port RST  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port nHEX  input  7  asynchronous segment bus, order gfedcba, 0 = segment lit.
REQ-005 The block SHALL have port DOUT  output  4  captured digit 0..9, else 0.
REQ-006 The block SHALL have port VALID  output  1  high while the captured pattern is a legal digit.
REQ-007 The block SHALL have port BLANK  output  1  high while the captured pattern is 7'b1111111.
REQ-008 The block SHALL have port ERR  output  1  high while the captured pattern is neither a digit nor blank.
REQ-009 The block SHALL have port UPD  output  1  one-cycle pulse on each new capture.
REQ-010 The block SHALL use one clock with a synchronous, active-high reset; the clock port is CLK and the reset port is RST.

Function
REQ-011 The block SHALL pass nHEX through a 2-stage synchronizer (s1, s2); only s2 feeds the rest of the logic.
REQ-012 The block SHALL hold register last (7 bits) and counter cnt (width clog2(STABLE_CYC+1)).
REQ-013 On each edge, if s2 != last, the block SHALL load last <= s2 and cnt <= 1.
REQ-014 On each edge, if s2 == last and cnt < STABLE_CYC, the block SHALL increment cnt; otherwise cnt SHALL saturate at STABLE_CYC.
REQ-015 The block SHALL commit when cnt == STABLE_CYC and (have_cap == 0 or last != cap); on commit it SHALL set cap <= last, have_cap <= 1 and UPD <= 1 for exactly one cycle.
REQ-016 The block SHALL hold UPD at 0 in all cycles without a commit.
REQ-017 The block SHALL decode on commit using this table: 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9.
REQ-018 For a table match, the block SHALL set DOUT=digit, VALID=1, BLANK=0, ERR=0.
REQ-019 For 1111111, the block SHALL set DOUT=0, VALID=0, BLANK=1, ERR=0.
REQ-020 For any other pattern, the block SHALL set DOUT=0, VALID=0, BLANK=0, ERR=1.
REQ-021 After the first commit, exactly one of VALID, BLANK and ERR SHALL be high; outputs SHALL change only on a commit edge.
REQ-022 Latency: a new pattern held constant on nHEX SHALL produce UPD high in the cycle after the (STABLE_CYC+3)th rising edge following the change.
REQ-023 Glitch rule: a pattern that changes before cnt reaches STABLE_CYC SHALL restart counting and SHALL NOT commit.
REQ-024 Re-stabilising on a pattern equal to cap SHALL NOT commit and SHALL NOT pulse UPD.
REQ-025 Simultaneous events: when s2 != last on a cycle where the commit condition holds, the commit SHALL still occur using the old last, and counting SHALL restart for the new value.

Reset
REQ-026 While RST=1 at an edge, the block SHALL set s1=s2=last=7'b1111111, cnt=0, cap=7'b1111111, have_cap=0, DOUT=0, VALID=0, BLANK=0, ERR=0, UPD=0.
REQ-027 RST SHALL override any in-progress count or commit in the same edge, including reset asserted mid-operation.
REQ-028 After RST deasserts with nHEX held at 1111111, the first commit (BLANK=1, UPD pulse) SHALL occur on the (STABLE_CYC+1)th edge.

Verification (STABLE_CYC=4)
REQ-029 Reset released with nHEX=1111111 -> UPD high after edge 5; BLANK=1, VALID=0, ERR=0, DOUT=0.
REQ-030 nHEX 1111111 -> 0100100 held -> UPD high after 7th edge; DOUT=2, VALID=1.
REQ-031 From captured 2, drive 1111001 for 3 cycles, then 0100100 -> no UPD pulse; DOUT stays 2.
REQ-032 nHEX=0000001 held 10 cycles -> one UPD pulse; ERR=1, VALID=0, DOUT=0.
REQ-033 Sweep digits 0..9, each held 10 cycles -> 10 UPD pulses; DOUT follows 0..9 with VALID=1 throughout.
REQ-034 RST pulsed for 1 cycle while cnt=2 -> next cycle all outputs 0, then blank capture per REQ-028.

Source files
------------

// File: rtl/seg7_capture.sv
`default_nettype none
// ============================================================================
// Module  : seg7_capture
// Purpose : Debounces an active-low 7-segment bus and decodes stable digits.
// Rev     : 1.0
// ============================================================================
module seg7_capture #(
    parameter int STABLE_CYC = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] nHEX,
    output logic [3:0] DOUT,
    output logic       VALID,
    output logic       BLANK,
    output logic       ERR,
    output logic       UPD
);

    localparam int               CNT_W     = $clog2(STABLE_CYC + 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(STABLE_CYC);
    localparam logic [6:0]       C_BLANK   = 7'b1111111;

    logic [6:0]       s1_q, s1_d;
    logic [6:0]       s2_q, s2_d;
    logic [6:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       cap_q, cap_d;
    logic             have_cap_q, have_cap_d;
    logic [3:0]       dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             blank_q, blank_d;
    logic             err_q, err_d;
    logic             upd_q, upd_d;

    logic             w_commit;
    logic             w_dec_hit;
    logic [3:0]       w_dec_digit;

    always_comb begin
        w_dec_hit   = 1'b1;
        w_dec_digit = 4'd0;
        case (last_q)
            7'b1000000: w_dec_digit = 4'd0;
            7'b1111001: w_dec_digit = 4'd1;
            7'b0100100: w_dec_digit = 4'd2;
            7'b0110000: w_dec_digit = 4'd3;
            7'b0011001: w_dec_digit = 4'd4;
            7'b0010010: w_dec_digit = 4'd5;
            7'b0000010: w_dec_digit = 4'd6;
            7'b1111000: w_dec_digit = 4'd7;
            7'b0000000: w_dec_digit = 4'd8;
            7'b0010000: w_dec_digit = 4'd9;
            default:    w_dec_hit   = 1'b0;
        endcase
    end

    // Commit looks at the registered last/cnt, so a change arriving on the
    // same edge still lets the old stable value commit.
    assign w_commit = (cnt_q == C_CNT_MAX) && (!have_cap_q || (last_q != cap_q));

    always_comb begin
        s1_d       = nHEX;
        s2_d       = s1_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        cap_d      = cap_q;
        have_cap_d = have_cap_q;
        dout_d     = dout_q;
        valid_d    = valid_q;
        blank_d    = blank_q;
        err_d      = err_q;
        upd_d      = w_commit;

        if (s2_q != last_q) begin
            last_d = s2_q;
            cnt_d  = CNT_W'(1);
        end else if (cnt_q < C_CNT_MAX) begin
            cnt_d  = cnt_q + CNT_W'(1);
        end

        if (w_commit) begin
            cap_d      = last_q;
            have_cap_d = 1'b1;
            dout_d     = w_dec_hit ? w_dec_digit : 4'd0;
            valid_d    = w_dec_hit;
            blank_d    = !w_dec_hit && (last_q == C_BLANK);
            err_d      = !w_dec_hit && (last_q != C_BLANK);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q       <= C_BLANK;
            s2_q       <= C_BLANK;
            last_q     <= C_BLANK;
            cnt_q      <= '0;
            cap_q      <= C_BLANK;
            have_cap_q <= 1'b0;
            dout_q     <= 4'd0;
            valid_q    <= 1'b0;
            blank_q    <= 1'b0;
            err_q      <= 1'b0;
            upd_q      <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            cap_q      <= cap_d;
            have_cap_q <= have_cap_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            blank_q    <= blank_d;
            err_q      <= err_d;
            upd_q      <= upd_d;
        end
    end

    assign DOUT  = dout_q;
    assign VALID = valid_q;
    assign BLANK = blank_q;
    assign ERR   = err_q;
    assign UPD   = upd_q;

endmodule
`default_nettype wire
